if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-002 SHALL provide port clk  input  1: sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL provide port stall  input  1: hazard-unit hold request for PC and IF/ID.
REQ-005 SHALL provide port redirect  input  1: branch/jump taken in ID; flush and load new PC.
REQ-006 SHALL provide port redirect_pc  input  32: target PC for redirect.
REQ-007 SHALL provide port imem_ready  input  1: instruction memory has valid data this cycle.
REQ-008 SHALL provide port imem_rdata  input  32: instruction word at imem_addr, valid when imem_ready=1.
REQ-009 SHALL provide port imem_addr  output  32: fetch address, equal to current PC.
REQ-010 SHALL provide port id_instr  output  32: registered instruction to ID.
REQ-011 SHALL provide port id_pc4  output  32: registered PC+4 of that instruction.
REQ-012 SHALL provide port id_valid  output  1: id_instr is a real instruction, not a bubble.
REQ-013 SHALL provide port id_imm  output  16: id_instr[15:0], feeds the immediate extender.
REQ-014 SHALL provide port id_extop  output  1: registered extender select; 1 zero-extend, 0 sign-extend.

Function
REQ-015 SHALL hold PC in a 32-bit register; imem_addr SHALL equal PC combinationally.
REQ-016 SHALL apply per-edge priority: redirect > stall > imem miss (imem_ready=0) > normal fetch.
REQ-017 Normal fetch SHALL set PC <= PC+4, id_instr <= imem_rdata, id_pc4 <= PC+4, id_valid <= 1.
REQ-018 Redirect SHALL set PC <= {redirect_pc[31:2],2'b00}, id_instr <= 0, id_valid <= 0, regardless of stall or imem_ready.
REQ-019 Stall without redirect SHALL hold PC, id_instr, id_pc4, id_valid, id_extop unchanged.
REQ-020 Imem miss without stall/redirect SHALL hold PC and load bubble: id_instr <= 0, id_valid <= 0, id_pc4 unchanged.
REQ-021 PC+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 id_extop SHALL be registered alongside id_instr: 1 when imem_rdata[31:26] is 6'h0C (andi), 6'h0D (ori), 6'h0E (xori) or 6'h0F (lui); else 0; 0 on bubble.
REQ-023 id_imm SHALL be id_instr[15:0] combinationally; zero during bubbles.
REQ-024 A bubble (id_valid=0) SHALL always carry id_instr=32'h0000_0000 (sll $0,$0,0).
REQ-025 Fetch latency SHALL be one cycle: instruction at PC appears on id_instr the edge after imem_ready=1 with no stall/redirect.

Reset
REQ-026 While rst_n=0 SHALL force PC=RESET_PC, id_instr=0, id_pc4=0, id_valid=0, id_extop=0, asynchronously.
REQ-027 On rst_n rising, first edge SHALL fetch from RESET_PC; reset mid-stall or mid-redirect SHALL discard pending redirect/stall state (no state beyond listed registers).

Verification
REQ-028 Reset then imem_ready=1, rdata 32'h3C01_1234 (lui) -> after 1 edge id_instr=32'h3C01_1234, id_pc4=32'h0000_3004, id_extop=1, id_valid=1, PC=32'h0000_3004.
REQ-029 Fetch 32'h8C22_FFFC (lw) then stall=1 for 3 cycles -> id_instr, id_pc4, PC frozen 3 cycles, id_extop=0, id_imm=16'hFFFC.
REQ-030 stall=1 and redirect=1 same edge, redirect_pc=32'h0000_3041 -> PC=32'h0000_3040, id_valid=0, id_instr=0.
REQ-031 imem_ready=0 for 2 cycles at PC=32'h0000_3008 -> 2 bubbles, PC stays 32'h0000_3008, then resumes with id_pc4=32'h0000_300C.
REQ-032 Redirect to 32'hFFFF_FFFC, normal fetch -> PC=32'h0000_0000, id_pc4=32'h0000_0000.
REQ-033 Assert rst_n=0 mid-cycle during stall -> outputs reset immediately without a clock edge, PC=RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: instruction memory fetch bus between the fetch stage and imem
interface if_stage_if;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master (output addr, input ready, input rdata);
  modport slave (input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC register and IF/ID pipeline register with redirect, stall and imem-miss handling
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_stage_if.master         imem,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic [15:0]        id_imm,
  output logic               id_extop
);
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        extop;
  assign pc4 = pc + 32'd4;
  assign imem.addr = pc;
  assign id_imm = id_instr[15:0];
  assign extop = imem.rdata[31:28] == 4'b0011;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      id_instr <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
      id_extop <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      id_instr <= '0;
      id_valid <= 1'b0;
      id_extop <= 1'b0;
    end else if (!stall) begin
      pc       <= imem.ready ? pc4 : pc;
      id_instr <= imem.ready ? imem.rdata : '0;
      id_pc4   <= imem.ready ? pc4 : id_pc4;
      id_valid <= imem.ready;
      id_extop <= imem.ready & extop;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table, reset corner cases and randomized run against a reference model
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] id_instr, id_pc4;
  logic        id_valid, id_extop;
  logic [15:0] id_imm;
  int          checks = 0;
  int          errors = 0;
  if_stage_if bus ();
  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus.master), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .id_imm(id_imm), .id_extop(id_extop)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        stall, redirect, ready;
    logic [31:0] rpc, rdata;
    logic [31:0] pc, instr, pc4;
    logic        valid, extop;
  } vec_t;
  vec_t vt[14];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_extop;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic valid, input logic extop);
    chk("pc", bus.addr, pc);
    chk("id_instr", id_instr, instr);
    chk("id_pc4", id_pc4, pc4);
    chk("id_valid", {31'd0, id_valid}, {31'd0, valid});
    chk("id_extop", {31'd0, id_extop}, {31'd0, extop});
    chk("id_imm", {16'd0, id_imm}, {16'd0, instr[15:0]});
  endtask
  task automatic model_step();
    logic [5:0] op;
    op = bus.rdata[31:26];
    if (redirect) begin
      m_pc = redirect_pc - (redirect_pc % 4);
      m_instr = 0; m_valid = 0; m_extop = 0;
    end else if (!stall) begin
      if (bus.ready) begin
        m_pc = m_pc + 4;
        m_pc4 = m_pc;
        m_instr = bus.rdata; m_valid = 1;
        m_extop = (op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F);
      end else begin
        m_instr = 0; m_valid = 0; m_extop = 0;
      end
    end
  endtask
  initial begin
    vt[0]  = '{0, 0, 1, 32'h0, 32'h3C01_1234, 32'h0000_3004, 32'h3C01_1234, 32'h0000_3004, 1, 1};
    vt[1]  = '{0, 0, 1, 32'h0, 32'h8C22_FFFC, 32'h0000_3008, 32'h8C22_FFFC, 32'h0000_3008, 1, 0};
    vt[2]  = '{1, 0, 1, 32'h0, 32'h1234_5678, 32'h0000_3008, 32'h8C22_FFFC, 32'h0000_3008, 1, 0};
    vt[3]  = '{1, 0, 0, 32'h0, 32'h3C00_0000, 32'h0000_3008, 32'h8C22_FFFC, 32'h0000_3008, 1, 0};
    vt[4]  = '{1, 0, 1, 32'h0, 32'h3400_0001, 32'h0000_3008, 32'h8C22_FFFC, 32'h0000_3008, 1, 0};
    vt[5]  = '{0, 0, 0, 32'h0, 32'h3C01_AAAA, 32'h0000_3008, 32'h0000_0000, 32'h0000_3008, 0, 0};
    vt[6]  = '{0, 0, 0, 32'h0, 32'hDEAD_BEEF, 32'h0000_3008, 32'h0000_0000, 32'h0000_3008, 0, 0};
    vt[7]  = '{0, 0, 1, 32'h0, 32'h34A5_00FF, 32'h0000_300C, 32'h34A5_00FF, 32'h0000_300C, 1, 1};
    vt[8]  = '{1, 1, 1, 32'h0000_3041, 32'h3C01_1111, 32'h0000_3040, 32'h0, 32'h0000_300C, 0, 0};
    vt[9]  = '{0, 1, 0, 32'hFFFF_FFFF, 32'h3C01_2222, 32'hFFFF_FFFC, 32'h0, 32'h0000_300C, 0, 0};
    vt[10] = '{0, 0, 1, 32'h0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 1, 0};
    vt[11] = '{0, 0, 1, 32'h0, 32'h3800_0001, 32'h0000_0004, 32'h3800_0001, 32'h0000_0004, 1, 1};
    vt[12] = '{0, 0, 1, 32'h0, 32'h3000_0000, 32'h0000_0008, 32'h3000_0000, 32'h0000_0008, 1, 1};
    vt[13] = '{0, 0, 1, 32'h0, 32'h4000_0000, 32'h0000_000C, 32'h4000_0000, 32'h0000_000C, 1, 0};
    bus.ready = 1'b0;
    bus.rdata = '0;
    #12;
    chk_all(32'h0000_3000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      stall = vt[i].stall; redirect = vt[i].redirect; redirect_pc = vt[i].rpc;
      bus.ready = vt[i].ready; bus.rdata = vt[i].rdata;
      @(posedge clk);
      #1 chk_all(vt[i].pc, vt[i].instr, vt[i].pc4, vt[i].valid, vt[i].extop);
    end
    @(negedge clk);
    stall = 1'b1; redirect = 1'b0; bus.ready = 1'b1; bus.rdata = 32'h3C05_0005;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all(32'h0000_3000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    @(posedge clk);
    #1 chk_all(32'h0000_3004, 32'h3C05_0005, 32'h0000_3004, 1, 1);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    #2 rst_n = 1'b0;
    #1 chk_all(32'h0000_3000, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; redirect = 1'b0; bus.rdata = 32'h8C00_0010;
    @(posedge clk);
    #1 chk_all(32'h0000_3004, 32'h8C00_0010, 32'h0000_3004, 1, 0);
    m_pc = 32'h0000_3004; m_instr = 32'h8C00_0010; m_pc4 = 32'h0000_3004; m_valid = 1; m_extop = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      bus.ready = ($urandom_range(0, 3) != 0);
      bus.rdata = {($urandom_range(0, 1) == 0) ? 6'(4'd12 + $urandom_range(0, 3)) : 6'($urandom), 26'($urandom)};
      model_step();
      @(posedge clk);
      #1 chk_all(m_pc, m_instr, m_pc4, m_valid, m_extop);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
